// File: rtl/param_shadow.sv
// Parameter shadow stage: synchronizes the decoder's receive-done flag, stages and
// validates a parameter set, and commits it to the sequencer only on a period boundary.
module param_shadow #(
  parameter int unsigned SETTLE  = 4,
  parameter logic [31:0] DEF_PER = 32'd2000,
  parameter logic [15:0] DEF_P1  = 16'd30,
  parameter logic [15:0] DEF_DEL = 16'd200,
  parameter logic [15:0] DEF_P2  = 16'd60,
  parameter int unsigned MARGIN  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd_async,
  input  logic [31:0] per_in,
  input  logic [15:0] p1wid_in,
  input  logic [15:0] del_in,
  input  logic [15:0] p2wid_in,
  input  logic [15:0] nut_d_in,
  input  logic [7:0]  nut_w_in,
  input  logic [7:0]  cp_in,
  input  logic [7:0]  p_bl_in,
  input  logic [15:0] p_bl_hf_in,
  input  logic        bl_in,
  input  logic        cycle_end,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [15:0] nut_d,
  output logic [7:0]  nut_w,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_hf,
  output logic        bl,
  output logic        pending,
  output logic        update,
  output logic        err
);

  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [31:0] MARGIN_W  = 32'(MARGIN);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_PEND} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        update_q;
  logic [2:0]  sync_q;
  logic        rx_edge;
  logic        capture, commit, reject;
  logic [31:0] need;

  // Staging set
  logic [31:0] stg_per_q;
  logic [15:0] stg_p1_q, stg_del_q, stg_p2_q, stg_nut_d_q, stg_p_bl_hf_q;
  logic [7:0]  stg_nut_w_q, stg_cp_q, stg_p_bl_q;
  logic        stg_bl_q;

  // Committed set
  logic [31:0] per_q;
  logic [15:0] p1_q, del_q, p2_q, nut_d_q, p_bl_hf_q;
  logic [7:0]  nut_w_q, cp_q, p_bl_q;
  logic        bl_q;

  // Two-flop synchronizer plus one flop for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], rxd_async};
  end

  assign rx_edge = sync_q[1] & ~sync_q[2];

  assign need   = 32'(stg_p1_q) + 32'(stg_del_q) + 32'(stg_p2_q) + MARGIN_W;
  assign reject = (stg_per_q == 32'd0) || (stg_per_q < need);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      update_q <= commit;
    end
  end

  // A new rx_edge in any busy state restarts settling; the newest command wins,
  // including over a cycle_end arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (rx_edge) begin
          cnt_d = SETTLE_LD;
        end else if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if (rx_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end else if (reject) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_d   = 1'b0;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (rx_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end else if (cycle_end) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stg_per_q     <= '0;
      stg_p1_q      <= '0;
      stg_del_q     <= '0;
      stg_p2_q      <= '0;
      stg_nut_d_q   <= '0;
      stg_nut_w_q   <= '0;
      stg_cp_q      <= '0;
      stg_p_bl_q    <= '0;
      stg_p_bl_hf_q <= '0;
      stg_bl_q      <= 1'b0;
    end else if (capture) begin
      stg_per_q     <= per_in;
      stg_p1_q      <= p1wid_in;
      stg_del_q     <= del_in;
      stg_p2_q      <= p2wid_in;
      stg_nut_d_q   <= nut_d_in;
      stg_nut_w_q   <= nut_w_in;
      stg_cp_q      <= cp_in;
      stg_p_bl_q    <= p_bl_in;
      stg_p_bl_hf_q <= p_bl_hf_in;
      stg_bl_q      <= bl_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      per_q     <= DEF_PER;
      p1_q      <= DEF_P1;
      del_q     <= DEF_DEL;
      p2_q      <= DEF_P2;
      nut_d_q   <= '0;
      nut_w_q   <= '0;
      cp_q      <= '0;
      p_bl_q    <= '0;
      p_bl_hf_q <= '0;
      bl_q      <= 1'b0;
    end else if (commit) begin
      per_q     <= stg_per_q;
      p1_q      <= stg_p1_q;
      del_q     <= stg_del_q;
      p2_q      <= stg_p2_q;
      nut_d_q   <= stg_nut_d_q;
      nut_w_q   <= stg_nut_w_q;
      cp_q      <= stg_cp_q;
      p_bl_q    <= stg_p_bl_q;
      p_bl_hf_q <= stg_p_bl_hf_q;
      bl_q      <= stg_bl_q;
    end
  end

  assign per     = per_q;
  assign p1wid   = p1_q;
  assign del     = del_q;
  assign p2wid   = p2_q;
  assign nut_d   = nut_d_q;
  assign nut_w   = nut_w_q;
  assign cp      = cp_q;
  assign p_bl    = p_bl_q;
  assign p_bl_hf = p_bl_hf_q;
  assign bl      = bl_q;
  assign pending = (state_q == ST_PEND);
  assign update  = update_q;
  assign err     = err_q;

endmodule

// File: tb/tb_param_shadow.sv
// Directed bench for param_shadow: reset values, commit timing, reject, restart, boundary, async reset.
module tb_param_shadow;
  logic        clk, resetn, rxd_async, cycle_end;
  logic [31:0] per_in;
  logic [15:0] p1wid_in, del_in, p2wid_in, nut_d_in, p_bl_hf_in;
  logic [7:0]  nut_w_in, cp_in, p_bl_in;
  logic        bl_in;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_hf;
  logic [7:0]  nut_w, cp, p_bl;
  logic        bl, pending, update, err;

  int n_chk = 0;
  int n_err = 0;

  param_shadow dut (
    .clk(clk), .resetn(resetn), .rxd_async(rxd_async),
    .per_in(per_in), .p1wid_in(p1wid_in), .del_in(del_in), .p2wid_in(p2wid_in),
    .nut_d_in(nut_d_in), .nut_w_in(nut_w_in), .cp_in(cp_in), .p_bl_in(p_bl_in),
    .p_bl_hf_in(p_bl_hf_in), .bl_in(bl_in), .cycle_end(cycle_end),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .nut_d(nut_d),
    .nut_w(nut_w), .cp(cp), .p_bl(p_bl), .p_bl_hf(p_bl_hf), .bl(bl),
    .pending(pending), .update(update), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_bus(input logic [31:0] pr, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] b);
    per_in = pr; p1wid_in = a; del_in = d; p2wid_in = b;
  endtask

  // rxd held 4 cycles, then low; by return any accepted set is pending.
  task automatic send_cmd();
    rxd_async = 1'b1;
    tick(4);
    rxd_async = 1'b0;
    tick(8);
  endtask

  task automatic pulse_end();
    cycle_end = 1'b1;
    tick();
    cycle_end = 1'b0;
  endtask

  initial begin
    logic saw_pend;
    resetn = 1'b0; rxd_async = 1'b0; cycle_end = 1'b0;
    per_in = $urandom; p1wid_in = 16'($urandom); del_in = 16'($urandom); p2wid_in = 16'($urandom);
    nut_d_in = 16'($urandom); nut_w_in = 8'($urandom); cp_in = 8'($urandom);
    p_bl_in = 8'($urandom); p_bl_hf_in = 16'($urandom); bl_in = 1'($urandom);
    tick(3);
    resetn = 1'b1;
    tick();
    chk("rst_per", per, 2000);
    chk("rst_p1", 32'(p1wid), 30);
    chk("rst_del", 32'(del), 200);
    chk("rst_p2", 32'(p2wid), 60);
    chk("rst_nut_d", 32'(nut_d), 0);
    chk("rst_nut_w", 32'(nut_w), 0);
    chk("rst_cp", 32'(cp), 0);
    chk("rst_p_bl", 32'(p_bl), 0);
    chk("rst_p_bl_hf", 32'(p_bl_hf), 0);
    chk("rst_bl", 32'(bl), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_update", 32'(update), 0);
    chk("rst_err", 32'(err), 0);

    // cycle_end while idle is ignored
    pulse_end();
    chk("idle_end_upd", 32'(update), 0);
    chk("idle_end_per", per, 2000);

    // Normal commit with exact pending timing (rxd rises before edge E0)
    set_bus(1000, 10, 100, 20);
    nut_d_in = 16'h1234; nut_w_in = 8'h56; cp_in = 8'h07; p_bl_in = 8'h09;
    p_bl_hf_in = 16'h0abc; bl_in = 1'b1;
    rxd_async = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 4) rxd_async = 1'b0;
      if (k == 6) chk("pend_E6", 32'(pending), 0);
      if (k == 7) chk("pend_E7", 32'(pending), 1);
    end
    tick(42);
    chk("pend_hold", 32'(pending), 1);
    chk("per_before_commit", per, 2000);
    pulse_end();
    chk("commit_upd", 32'(update), 1);
    chk("commit_pend", 32'(pending), 0);
    chk("commit_per", per, 1000);
    chk("commit_p1", 32'(p1wid), 10);
    chk("commit_del", 32'(del), 100);
    chk("commit_p2", 32'(p2wid), 20);
    chk("commit_nut_d", 32'(nut_d), 32'h1234);
    chk("commit_nut_w", 32'(nut_w), 32'h56);
    chk("commit_cp", 32'(cp), 7);
    chk("commit_p_bl", 32'(p_bl), 9);
    chk("commit_p_bl_hf", 32'(p_bl_hf), 32'h0abc);
    chk("commit_bl", 32'(bl), 1);
    tick();
    chk("upd_one_cycle", 32'(update), 0);

    // Reject: need = 134 > 130
    set_bus(130, 10, 100, 20);
    saw_pend = 1'b0;
    rxd_async = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 4) rxd_async = 1'b0;
      if (pending) saw_pend = 1'b1;
    end
    chk("rej_err", 32'(err), 1);
    chk("rej_never_pend", 32'(saw_pend), 0);
    pulse_end();
    chk("rej_no_upd", 32'(update), 0);
    chk("rej_per", per, 1000);

    // Boundary: per == need accepted, clears err
    set_bus(134, 10, 100, 20);
    send_cmd();
    chk("bnd_pend", 32'(pending), 1);
    chk("bnd_err_clr", 32'(err), 0);
    pulse_end();
    chk("bnd_upd", 32'(update), 1);
    chk("bnd_per", per, 134);

    // Restart: rx_edge and cycle_end in the same PENDING cycle
    set_bus(1000, 10, 100, 20);
    send_cmd();
    chk("rs_pend", 32'(pending), 1);
    per_in = 3000;
    rxd_async = 1'b1;
    tick();            // E0
    tick();            // E1: rx_edge is high until E2
    cycle_end = 1'b1;
    tick();            // E2: restart wins
    cycle_end = 1'b0;
    chk("rs_no_upd", 32'(update), 0);
    chk("rs_per_kept", per, 134);
    chk("rs_pend_drop", 32'(pending), 0);
    tick(2);
    rxd_async = 1'b0;
    tick(8);
    chk("rs_pend2", 32'(pending), 1);
    pulse_end();
    chk("rs_upd", 32'(update), 1);
    chk("rs_per", per, 3000);

    // Zero set rejected
    set_bus(0, 0, 0, 0);
    send_cmd();
    chk("zero_err", 32'(err), 1);
    chk("zero_pend", 32'(pending), 0);

    // Async reset while pending
    set_bus(500, 10, 100, 20);
    send_cmd();
    chk("ar_pend", 32'(pending), 1);
    chk("ar_err_clr", 32'(err), 0);
    #2 resetn = 1'b0;
    #1;
    chk("ar_per", per, 2000);
    chk("ar_p1", 32'(p1wid), 30);
    chk("ar_pend_drop", 32'(pending), 0);
    chk("ar_bl", 32'(bl), 0);
    tick(2);
    resetn = 1'b1;
    tick();
    pulse_end();
    chk("ar_no_upd", 32'(update), 0);
    chk("ar_per_after", per, 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
